// File: rtl/cpu_mul_pipeline.sv
// Fixed-latency in-order pipelined multiplier: low DATA_W bits of a*b after DEPTH stages.
// Per-stage destination tags are exported for mul RAW/WAW hazard checks.
module cpu_mul_pipeline #(
  parameter int DEPTH  = 5,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [REG_W-1:0]         issue_rd,
  input  logic [DATA_W-1:0]        issue_a,
  input  logic [DATA_W-1:0]        issue_b,
  input  logic                     flush,
  input  logic                     freeze,
  output logic [DEPTH-1:0]         tag_wb,
  output logic [DEPTH*REG_W-1:0]   tag_rd,
  output logic                     wb_valid,
  output logic [REG_W-1:0]         wb_rd,
  output logic [DATA_W-1:0]        wb_data
);

  localparam int H = DATA_W / 2;

  logic                                accept;
  logic [DEPTH-1:0]                    valid_q, valid_d;
  logic [DEPTH-1:0][REG_W-1:0]         rd_q, rd_d;
  logic [DATA_W-1:0]                   ll_q, ll_d;
  logic [H-1:0]                        lh_q, lh_d;
  logic [H-1:0]                        hl_q, hl_d;
  logic [DATA_W-1:0]                   ll1_q, ll1_d;
  logic [H-1:0]                        cross_q, cross_d;
  logic [DEPTH-1:2][DATA_W-1:0]        prod_q, prod_d;

  assign accept      = issue_valid && !freeze && !flush;
  assign issue_ready = !freeze;

  // Only the low half of each cross term can reach the low DATA_W bits of the product.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    ll_d    = ll_q;
    lh_d    = lh_q;
    hl_d    = hl_q;
    ll1_d   = ll1_q;
    cross_d = cross_q;
    prod_d  = prod_q;
    if (!freeze) begin
      valid_d = {valid_q[DEPTH-2:0], accept};
      rd_d    = {rd_q[DEPTH-2:0], issue_rd};
      ll_d    = {{H{1'b0}}, issue_a[H-1:0]} * {{H{1'b0}}, issue_b[H-1:0]};
      lh_d    = issue_a[H-1:0] * issue_b[DATA_W-1:H];
      hl_d    = issue_a[DATA_W-1:H] * issue_b[H-1:0];
      ll1_d   = ll_q;
      cross_d = lh_q + hl_q;
      prod_d[2] = ll1_q + {cross_q, {H{1'b0}}};
      for (int i = 3; i < DEPTH; i++) begin
        prod_d[i] = prod_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      rd_q    <= '0;
      ll_q    <= '0;
      lh_q    <= '0;
      hl_q    <= '0;
      ll1_q   <= '0;
      cross_q <= '0;
      prod_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      ll_q    <= ll_d;
      lh_q    <= lh_d;
      hl_q    <= hl_d;
      ll1_q   <= ll1_d;
      cross_q <= cross_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    tag_wb = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tag_wb[i] = valid_q[i] && (rd_q[i] != '0);
    end
  end

  assign tag_rd   = rd_q;
  assign wb_valid = valid_q[DEPTH-1] && !freeze && (rd_q[DEPTH-1] != '0);
  assign wb_rd    = rd_q[DEPTH-1];
  assign wb_data  = prod_q[DEPTH-1];

endmodule

// File: tb/tb_cpu_mul_pipeline.sv
// Self-checking bench for cpu_mul_pipeline: directed scenarios plus random traffic
// compared against an in-flight list model (entries aged by unfrozen cycles).
module tb_cpu_mul_pipeline;

  localparam int DEPTH  = 5;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   issue_valid;
  logic                   issue_ready;
  logic [REG_W-1:0]       issue_rd;
  logic [DATA_W-1:0]      issue_a;
  logic [DATA_W-1:0]      issue_b;
  logic                   flush;
  logic                   freeze;
  logic [DEPTH-1:0]       tag_wb;
  logic [DEPTH*REG_W-1:0] tag_rd;
  logic                   wb_valid;
  logic [REG_W-1:0]       wb_rd;
  logic [DATA_W-1:0]      wb_data;

  cpu_mul_pipeline #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_rd    (issue_rd),
    .issue_a     (issue_a),
    .issue_b     (issue_b),
    .flush       (flush),
    .freeze      (freeze),
    .tag_wb      (tag_wb),
    .tag_rd      (tag_rd),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // In-flight MULs, oldest first; age = unfrozen edges since acceptance.
  int                q_age[$];
  logic [REG_W-1:0]  q_rd[$];
  logic [DATA_W-1:0] q_prod[$];
  bit                just_rst;
  int                n_retired;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic v, input logic [REG_W-1:0] rd,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic fl, input logic fr, input logic rn);
    logic [DEPTH-1:0]       exp_tag;
    logic [DEPTH*REG_W-1:0] exp_rd, mask;
    logic                   exp_wbv;
    logic [DATA_W-1:0]      p;
    issue_valid = v;
    issue_rd    = rd;
    issue_a     = a;
    issue_b     = b;
    flush       = fl;
    freeze      = fr;
    rst_n       = rn;
    @(negedge clk);
    exp_tag = '0;
    exp_rd  = '0;
    mask    = '0;
    foreach (q_age[j]) begin
      exp_tag[q_age[j]] = (q_rd[j] != '0);
      exp_rd[q_age[j]*REG_W +: REG_W] = q_rd[j];
      mask[q_age[j]*REG_W +: REG_W]   = '1;
    end
    exp_wbv = (q_age.size() > 0) && (q_age[0] == DEPTH-1) && !fr && (q_rd[0] != '0);
    chk("issue_ready", issue_ready, !fr);
    chk("tag_wb", tag_wb, exp_tag);
    chk("tag_rd", tag_rd & mask, exp_rd);
    chk("wb_valid", wb_valid, exp_wbv);
    if (exp_wbv) begin
      chk("wb_rd", wb_rd, q_rd[0]);
      chk("wb_data", wb_data, q_prod[0]);
      n_retired++;
    end
    if (just_rst) begin
      chk("rst_tag_rd", tag_rd, '0);
      chk("rst_wb_data", wb_data, '0);
      chk("rst_wb_rd", wb_rd, '0);
    end
    @(posedge clk);
    if (!rn) begin
      q_age.delete();
      q_rd.delete();
      q_prod.delete();
      just_rst = 1'b1;
    end else begin
      just_rst = 1'b0;
      if (!fr) begin
        foreach (q_age[j]) q_age[j]++;
        if (q_age.size() > 0 && q_age[0] == DEPTH) begin
          void'(q_age.pop_front());
          void'(q_rd.pop_front());
          void'(q_prod.pop_front());
        end
        if (v && !fl) begin
          p = a * b;
          q_age.push_back(0);
          q_rd.push_back(rd);
          q_prod.push_back(p);
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int retired_before;
    n_retired   = 0;
    just_rst    = 1'b0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    issue_a     = '0;
    issue_b     = '0;
    flush       = 1'b0;
    freeze      = 1'b0;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    just_rst = 1'b1;

    // single issue 7*6 -> r3
    cycle(1'b1, 5'd3, 32'd7, 32'd6, 1'b0, 1'b0, 1'b1);
    idle(DEPTH + 1);

    // back-to-back i * 0xFFFFFFFF into r1..r5
    for (int i = 1; i <= 5; i++)
      cycle(1'b1, REG_W'(i), DATA_W'(i), 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    idle(DEPTH + 1);

    // freeze cycles 2-4 after issue
    cycle(1'b1, 5'd9, 32'd3, 32'd5, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    idle(DEPTH + 1);

    // flush, then rd=0, then flush+freeze together
    cycle(1'b1, 5'd4, 32'd9, 32'd9, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 5'd0, 32'd2, 32'd2, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 5'd6, 32'd1, 32'd1, 1'b1, 1'b1, 1'b1);
    idle(DEPTH + 1);

    // reset with three MULs in flight: none may retire
    retired_before = n_retired;
    cycle(1'b1, 5'd10, 32'd11, 32'd12, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 5'd11, 32'd13, 32'd14, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 5'd12, 32'd15, 32'd16, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    idle(DEPTH + 1);
    chk("rst_no_retire", n_retired, retired_before);

    // overflow wraps to zero
    cycle(1'b1, 5'd7, 32'h8000_0000, 32'd2, 1'b0, 1'b0, 1'b1);
    idle(DEPTH + 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [REG_W-1:0] r;
      r = ($urandom_range(0, 7) == 0) ? '0 : REG_W'($urandom);
      cycle(1'($urandom_range(0, 3) != 0), r, $urandom, $urandom,
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 49) != 0));
    end
    idle(DEPTH + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
